piece_move_ctrl: RTL
====================

// Module: piece_move_ctrl
// PURPOSE
//  Owns the active falling piece: block type, rotation, X/Y origin. Sequences spawn/left/right/down/rotate
//  requests by forming a candidate pose, expanding it to 4 cell offsets via the shared shape LUT, and checking
//  each cell against bounds and board occupancy. Commits the pose only if all cells are free. Sits between
//  input/gravity logic and the board RAM/renderer.
// PARAMETERS
//  BOARD_W  10  board width in cells
//  BOARD_H  20  board height in cells
//  X_W      4   width of piece/board X coordinate
//  Y_W      5   width of piece/board Y coordinate
// PORTS
//  clk          in   1      single system clock
//  reset        in   1      synchronous, active-high
//  spawn        in   1      request: new piece of spawn_block at (3,0), rotation 0
//  spawn_block  in   3      0=I 1=J 2=L 3=O 4=S 5=T 6=Z; value 7 is rejected
//  move_left    in   1      request X-1
//  move_right   in   1      request X+1
//  move_down    in   1      request Y+1; gravity and soft drop
//  rotate       in   1      request rotation+1 mod 4
//  brd_rd_x     out  X_W    board occupancy read address X
//  brd_rd_y     out  Y_W    board occupancy read address Y
//  brd_occ      in   1      occupancy of the cell addressed on the previous cycle (1-cycle read latency)
//  piece_block  out  3      committed block type
//  piece_rot    out  2      committed rotation
//  piece_x      out  X_W    committed origin X
//  piece_y      out  Y_W    committed origin Y
//  piece_valid  out  1      a live piece exists
//  busy         out  1      request in progress; new requests are ignored
//  done         out  1      1-cycle pulse: request resolved, committed or rejected
//  accepted     out  1      valid with done: 1 = pose committed
//  landed       out  1      1-cycle pulse with done: move_down rejected, piece must be locked
//  game_over    out  1      sticky: spawn collided; cleared only by reset
// BEHAVIOUR
//  Reset values: all outputs 0. State IDLE. Reset mid-request aborts; no commit and no done.
//  FSM: IDLE -> CHECK (4 cycles, cell idx 0..3) -> DRAIN (1 cycle) -> RESOLVE (1 cycle) -> IDLE.
//  IDLE: sample requests only here, and only when !game_over. Priority: spawn > move_down > move_left >
//   move_right > rotate. Exactly one request is taken; the others are dropped. Moves and rotate are
//   ignored when piece_valid=0. spawn with block 7 is ignored. Taking a request latches the candidate
//   (blk,rot,x,y) and sets busy.
//  CHECK: internal lut driven by candidate blk/rot. Cell k = (cx + X[2k+1:2k], cy + Y[2k+1:2k]),
//   computed at X_W+1 / Y_W+1 bits, so no wrap is possible. Drive brd_rd_* = cell k.
//   Mark collision if cell X >= BOARD_W or cell Y >= BOARD_H.
//  Underflow: move_left with piece_x==0 is an immediate collision; the full sequence still runs
//   (fixed latency).
//  brd_occ is sampled one cycle after each address, in CHECK idx1..3 and DRAIN. Any 1 marks collision.
//  RESOLVE: on no collision, commit candidate to piece_* and set accepted=1. Spawn sets piece_valid=1.
//   On collision, piece_* is unchanged and accepted=0.
//   Rejected move_down: landed=1 and piece_valid<=0; piece_* is kept for the lock logic.
//   Rejected spawn: game_over<=1, piece_valid stays 0.
//  Latency: request taken at edge E0 -> busy=1 after E0. done/accepted/landed=1 for exactly the cycle
//   after E6, and busy=0 in that same cycle. The earliest next accept is E7 (7-cycle throughput).
//  Rotation wraps 3->0. Spawn overrides an existing piece; the caller spawns only after a landing.
// STRUCTURE
//  Shared include tetris_defs.vh: block codes, BOARD_W/H defaults, SPAWN_X=3, SPAWN_Y=0.
//  One sub-module: the existing shape LUT module `lut`, instantiated once on candidate blk/rot.
//  Colour output is not used here.
//  Board occupancy RAM is external.
// TESTING
//  Empty board; spawn block 5 (T) -> done at E6, accepted=1, piece (5,0,3,0), piece_valid=1.
//  I piece at x=6 rot0; move_right -> cell X=10 out of bounds: accepted=0, piece_x stays 6.
//   Then move_left x=6 -> 5.
//  O piece at y=18; move_down -> y=19 cells out of bounds: landed=1, piece_valid=0, piece_y stays 18.
//  brd_occ=1 only at (4,1); J at (3,0) rot0, rotate -> rot1 needs (4,0),(3,0),(3,1),(3,2): accepted=1.
//   Occupy (3,2) -> accepted=0.
//  Occupy (3,0); spawn -> game_over=1 sticky; later move/spawn ignored (no done); reset clears it.
//  move_down and move_left high at the same edge -> only down executes.
//   Assert reset at E3 mid-request -> no done, all outputs 0.

Source files
------------

// File: rtl/piece_move_ctrl_pkg.sv
// Shared types and constants for the active-piece controller: block codes,
// board defaults, spawn origin, FSM/request encodings and a shape helper.
package piece_move_ctrl_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int X_W_DEF     = 4;
  localparam int Y_W_DEF     = 5;
  localparam int SPAWN_X     = 3;
  localparam int SPAWN_Y     = 0;

  typedef enum logic [2:0] {
    BLK_I   = 3'd0,
    BLK_J   = 3'd1,
    BLK_L   = 3'd2,
    BLK_O   = 3'd3,
    BLK_S   = 3'd4,
    BLK_T   = 3'd5,
    BLK_Z   = 3'd6,
    BLK_BAD = 3'd7
  } blk_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESOLVE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    REQ_SPAWN = 3'd0,
    REQ_DOWN  = 3'd1,
    REQ_LEFT  = 3'd2,
    REQ_RIGHT = 3'd3,
    REQ_ROT   = 3'd4
  } req_e;

  // Four cell offsets, cell k in bits [2k+1:2k] of x and y.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } shape_t;

  function automatic shape_t mk_shape(input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2, input int x3, input int y3);
    shape_t s;
    s.x = {2'(x3), 2'(x2), 2'(x1), 2'(x0)};
    s.y = {2'(y3), 2'(y2), 2'(y1), 2'(y0)};
    return s;
  endfunction

endpackage

// File: rtl/piece_move_ctrl_lut.sv
// Shape LUT: block type + rotation -> four (x,y) cell offsets inside a 4x4 box.
// Shapes are packed against the top-left corner of the box.
module piece_move_ctrl_lut
  import piece_move_ctrl_pkg::*;
(
  input  logic [2:0] blk,
  input  logic [1:0] rot,
  output logic [7:0] ofs_x,
  output logic [7:0] ofs_y
);

  shape_t s;

  // Pure table lookup; code 7 falls back to the O shape.
  always_comb begin
    s = mk_shape(0,0, 1,0, 0,1, 1,1);
    case (blk)
      BLK_I: s = rot[0] ? mk_shape(0,0, 0,1, 0,2, 0,3) : mk_shape(0,0, 1,0, 2,0, 3,0);
      BLK_J:
        case (rot)
          2'd0:    s = mk_shape(0,0, 0,1, 1,1, 2,1);
          2'd1:    s = mk_shape(0,0, 1,0, 0,1, 0,2);
          2'd2:    s = mk_shape(0,0, 1,0, 2,0, 2,1);
          default: s = mk_shape(1,0, 1,1, 0,2, 1,2);
        endcase
      BLK_L:
        case (rot)
          2'd0:    s = mk_shape(2,0, 0,1, 1,1, 2,1);
          2'd1:    s = mk_shape(0,0, 0,1, 0,2, 1,2);
          2'd2:    s = mk_shape(0,0, 1,0, 2,0, 0,1);
          default: s = mk_shape(0,0, 1,0, 1,1, 1,2);
        endcase
      BLK_S: s = rot[0] ? mk_shape(0,0, 0,1, 1,1, 1,2) : mk_shape(1,0, 2,0, 0,1, 1,1);
      BLK_T:
        case (rot)
          2'd0:    s = mk_shape(1,0, 0,1, 1,1, 2,1);
          2'd1:    s = mk_shape(0,0, 0,1, 1,1, 0,2);
          2'd2:    s = mk_shape(0,0, 1,0, 2,0, 1,1);
          default: s = mk_shape(1,0, 0,1, 1,1, 1,2);
        endcase
      BLK_Z: s = rot[0] ? mk_shape(1,0, 0,1, 1,1, 0,2) : mk_shape(0,0, 1,0, 1,1, 2,1);
      default: ;
    endcase
  end

  assign ofs_x = s.x;
  assign ofs_y = s.y;

endmodule

// File: rtl/piece_move_ctrl.sv
// Active-piece controller. Takes one spawn/move/rotate request at a time, walks
// the candidate's four cells through bounds and board-occupancy checks, and
// commits the candidate pose only when every cell is free.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_IDLE    | waiting; requests sampled here only (and not after game over)
//  ST_CHECK   | idx 0..3: address cell idx, bounds-check it, sample occ of idx-1
//  ST_DRAIN   | sample occupancy of cell 3 (1-cycle read latency)
//  ST_RESOLVE | commit or reject; done/accepted/landed appear next cycle
module piece_move_ctrl
  import piece_move_ctrl_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spawn,
  input  logic [2:0]     spawn_block,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           move_down,
  input  logic           rotate,
  output logic [X_W-1:0] brd_rd_x,
  output logic [Y_W-1:0] brd_rd_y,
  input  logic           brd_occ,
  output logic [2:0]     piece_block,
  output logic [1:0]     piece_rot,
  output logic [X_W-1:0] piece_x,
  output logic [Y_W-1:0] piece_y,
  output logic           piece_valid,
  output logic           busy,
  output logic           done,
  output logic           accepted,
  output logic           landed,
  output logic           game_over
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(BOARD_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(BOARD_H);

  state_e         state, state_n;
  req_e           req, req_n;
  logic [1:0]     idx, idx_n;
  logic [2:0]     cand_blk, cand_blk_n;
  logic [1:0]     cand_rot, cand_rot_n;
  logic [X_W-1:0] cand_x, cand_x_n;
  logic [Y_W-1:0] cand_y, cand_y_n;
  logic           coll, coll_n;
  logic [2:0]     piece_block_n;
  logic [1:0]     piece_rot_n;
  logic [X_W-1:0] piece_x_n;
  logic [Y_W-1:0] piece_y_n;
  logic           piece_valid_n, done_n, accepted_n, landed_n, game_over_n;

  logic [7:0]     lut_x, lut_y;
  logic [X_W:0]   cell_x;
  logic [Y_W:0]   cell_y;

  piece_move_ctrl_lut u_lut (
    .blk   (cand_blk),
    .rot   (cand_rot),
    .ofs_x (lut_x),
    .ofs_y (lut_y)
  );

  // Cell coordinates carry one extra bit so an out-of-range cell never wraps.
  assign cell_x = {1'b0, cand_x} + {{(X_W-1){1'b0}}, lut_x[{idx, 1'b0} +: 2]};
  assign cell_y = {1'b0, cand_y} + {{(Y_W-1){1'b0}}, lut_y[{idx, 1'b0} +: 2]};
  assign busy   = (state != ST_IDLE);

  // Next-state, candidate, collision and commit logic.
  always_comb begin
    state_n       = state;
    req_n         = req;
    idx_n         = idx;
    cand_blk_n    = cand_blk;
    cand_rot_n    = cand_rot;
    cand_x_n      = cand_x;
    cand_y_n      = cand_y;
    coll_n        = coll;
    piece_block_n = piece_block;
    piece_rot_n   = piece_rot;
    piece_x_n     = piece_x;
    piece_y_n     = piece_y;
    piece_valid_n = piece_valid;
    game_over_n   = game_over;
    done_n        = 1'b0;
    accepted_n    = 1'b0;
    landed_n      = 1'b0;
    brd_rd_x      = '0;
    brd_rd_y      = '0;
    case (state)
      ST_IDLE: begin
        cand_blk_n = piece_block;
        cand_rot_n = piece_rot;
        cand_x_n   = piece_x;
        cand_y_n   = piece_y;
        coll_n     = 1'b0;
        idx_n      = 2'd0;
        if (!game_over) begin
          // A spawn with code 7 still wins priority, so it swallows the cycle.
          if (spawn) begin
            if (spawn_block != 3'(BLK_BAD)) begin
              state_n    = ST_CHECK;
              req_n      = REQ_SPAWN;
              cand_blk_n = spawn_block;
              cand_rot_n = 2'd0;
              cand_x_n   = X_W'(SPAWN_X);
              cand_y_n   = Y_W'(SPAWN_Y);
            end
          end else if (piece_valid) begin
            if (move_down) begin
              state_n  = ST_CHECK;
              req_n    = REQ_DOWN;
              cand_y_n = piece_y + 1'b1;
            end else if (move_left) begin
              state_n  = ST_CHECK;
              req_n    = REQ_LEFT;
              cand_x_n = piece_x - 1'b1;
              coll_n   = (piece_x == '0);
            end else if (move_right) begin
              state_n  = ST_CHECK;
              req_n    = REQ_RIGHT;
              cand_x_n = piece_x + 1'b1;
            end else if (rotate) begin
              state_n    = ST_CHECK;
              req_n      = REQ_ROT;
              cand_rot_n = piece_rot + 2'd1;
            end
          end
        end
      end
      ST_CHECK: begin
        brd_rd_x = cell_x[X_W-1:0];
        brd_rd_y = cell_y[Y_W-1:0];
        if ((cell_x >= X_LIM) || (cell_y >= Y_LIM)) coll_n = 1'b1;
        if ((idx != 2'd0) && brd_occ) coll_n = 1'b1;
        if (idx == 2'd3) state_n = ST_DRAIN;
        else             idx_n   = idx + 2'd1;
      end
      ST_DRAIN: begin
        if (brd_occ) coll_n = 1'b1;
        state_n = ST_RESOLVE;
      end
      default: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
        if (!coll) begin
          accepted_n    = 1'b1;
          piece_block_n = cand_blk;
          piece_rot_n   = cand_rot;
          piece_x_n     = cand_x;
          piece_y_n     = cand_y;
          if (req == REQ_SPAWN) piece_valid_n = 1'b1;
        end else if (req == REQ_DOWN) begin
          landed_n      = 1'b1;
          piece_valid_n = 1'b0;
        end else if (req == REQ_SPAWN) begin
          game_over_n = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= REQ_SPAWN;
      idx         <= '0;
      cand_blk    <= '0;
      cand_rot    <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      coll        <= 1'b0;
      piece_block <= '0;
      piece_rot   <= '0;
      piece_x     <= '0;
      piece_y     <= '0;
      piece_valid <= 1'b0;
      done        <= 1'b0;
      accepted    <= 1'b0;
      landed      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      req         <= req_n;
      idx         <= idx_n;
      cand_blk    <= cand_blk_n;
      cand_rot    <= cand_rot_n;
      cand_x      <= cand_x_n;
      cand_y      <= cand_y_n;
      coll        <= coll_n;
      piece_block <= piece_block_n;
      piece_rot   <= piece_rot_n;
      piece_x     <= piece_x_n;
      piece_y     <= piece_y_n;
      piece_valid <= piece_valid_n;
      done        <= done_n;
      accepted    <= accepted_n;
      landed      <= landed_n;
      game_over   <= game_over_n;
    end
  end

endmodule
